// File: rtl/dvi_pixel_rx.sv
// dvi_pixel_rx: DVI 12-bit half-pixel receiver with pixel FIFO; define DVI_RX_CRC_EN for per-frame CRC-16
module dvi_pixel_rx #(
  parameter int   FIFO_AW  = 4,
  parameter logic SYNC_POL = 1'b0,
  parameter int   XY_W     = 11
) (
  input  logic            clk_100,
  input  logic            reset,
  input  logic [11:0]     dvi_d,
  input  logic            dvi_de,
  input  logic            dvi_h,
  input  logic            dvi_v,
  output logic [23:0]     pixel_data,
  output logic [XY_W-1:0] pixel_x,
  output logic [XY_W-1:0] pixel_y,
  output logic            pixel_sof,
  output logic            pixel_valid,
  input  logic            ready,
  output logic            overflow,
  output logic            half_err,
  output logic [15:0]     frame_crc,
  output logic            crc_valid,
  output logic [7:0]      deb
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int FW    = 25 + 2 * XY_W;
  typedef enum logic [1:0] {WAIT_FRAME = 2'd0, IDLE = 2'd1, LO = 2'd2, HI = 2'd3} state_t;
  state_t            state_q, state_d;
  logic [11:0]       d_q;
  logic              de_q, de_p_q, h_q, v_q, vact_p_q;
  logic [11:0]       w0_q, w0_d;
  logic [XY_W-1:0]   x_q, x_d, y_q, y_d;
  logic              sof_q, sof_d, half_q, half_d, ovf_q, ovf_d;
  logic [FIFO_AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [FIFO_AW:0]  cnt_q, cnt_d;
  logic [FW-1:0]     mem [DEPTH];
  logic [FW-1:0]     last_q, last_d, head;
  logic              v_act, v_edge, de_rise, de_fall;
  logic              push, latch_w0, half_set, full, pop, wr_en, unused_h;
  assign v_act    = v_q == SYNC_POL;
  assign v_edge   = v_act && !vact_p_q;
  assign de_rise  = de_q && !de_p_q;
  assign de_fall  = !de_q && de_p_q;
  assign unused_h = h_q;
  // Register the pins once; sync regs start inactive so reset never fakes a v_edge
  always_ff @(posedge clk_100) begin
    if (!reset) begin
      d_q      <= '0;
      de_q     <= 1'b0;
      de_p_q   <= 1'b0;
      h_q      <= ~SYNC_POL;
      v_q      <= ~SYNC_POL;
      vact_p_q <= 1'b0;
    end else begin
      d_q      <= dvi_d;
      de_q     <= dvi_de;
      de_p_q   <= de_q;
      h_q      <= dvi_h;
      v_q      <= dvi_v;
      vact_p_q <= v_act;
    end
  end
  // State register
  always_ff @(posedge clk_100) begin
    if (!reset) state_q <= WAIT_FRAME;
    else        state_q <= state_d;
  end
  // Next state: LO holds word0 waiting for word1, HI has just completed a pixel
  always_comb begin
    state_d = state_q;
    if (v_edge) state_d = IDLE;
    else
      case (state_q)
        IDLE:    state_d = de_rise ? LO : IDLE;
        LO:      state_d = de_q ? HI : IDLE;
        HI:      state_d = de_q ? LO : IDLE;
        default: state_d = WAIT_FRAME;
      endcase
  end
  // FSM outputs; a v_edge discards any partial pixel
  always_comb begin
    push     = !v_edge && state_q == LO && de_q;
    latch_w0 = !v_edge && de_q && ((state_q == IDLE && de_rise) || state_q == HI);
    half_set = !v_edge && state_q == LO && !de_q;
  end
  // Position tracking, word0 holding and sticky half-pixel error
  always_comb begin
    w0_d   = latch_w0 ? d_q : w0_q;
    sof_d  = v_edge | (sof_q & ~push);
    half_d = half_q | half_set;
    x_d    = (v_edge || de_fall || (state_q == IDLE && de_rise)) ? '0 : push ? x_q + XY_W'(1) : x_q;
    y_d    = v_edge ? '0 : (de_fall && state_q != WAIT_FRAME) ? y_q + XY_W'(1) : y_q;
  end
  // FIFO control; the head register remembers the last popped entry for the empty case
  always_comb begin
    pop    = pixel_valid && ready;
    full   = cnt_q[FIFO_AW];
    wr_en  = push && (!full || pop);
    wr_d   = wr_q + FIFO_AW'(wr_en);
    rd_d   = rd_q + FIFO_AW'(pop);
    cnt_d  = cnt_q + (FIFO_AW + 1)'(wr_en) - (FIFO_AW + 1)'(pop);
    ovf_d  = ovf_q | (push & full & ~pop);
    last_d = pop ? mem[rd_q] : last_q;
    head   = pixel_valid ? mem[rd_q] : last_q;
  end
  // Datapath and FIFO state registers
  always_ff @(posedge clk_100) begin
    if (!reset) begin
      w0_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      sof_q  <= 1'b0;
      half_q <= 1'b0;
      ovf_q  <= 1'b0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      w0_q   <= w0_d;
      x_q    <= x_d;
      y_q    <= y_d;
      sof_q  <= sof_d;
      half_q <= half_d;
      ovf_q  <= ovf_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end
  // FIFO storage: {sof, y, x, word1, word0}
  always_ff @(posedge clk_100) begin
    if (reset && wr_en) mem[wr_q] <= {sof_q, y_q, x_q, d_q, w0_q};
  end
  assign pixel_valid = cnt_q != '0;
  assign {pixel_sof, pixel_y, pixel_x, pixel_data} = head;
  assign overflow = ovf_q;
  assign half_err = half_q;
  assign deb      = {state_q, 5'(cnt_q), ovf_q};
`ifdef DVI_RX_CRC_EN
  logic [15:0] crc_q, crc_d, fcrc_q, fcrc_d;
  logic        cv_q, cv_d, seen_q, seen_d;
  function automatic logic [15:0] crc24(input logic [15:0] c, input logic [23:0] p);
    logic [15:0] r;
    r = c;
    for (int i = 23; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ p[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction
  // Running CRC over accepted pixels; published at every frame start except the first
  always_comb begin
    crc_d  = v_edge ? 16'hFFFF : wr_en ? crc24(crc_q, {d_q, w0_q}) : crc_q;
    fcrc_d = (v_edge && seen_q) ? crc_q : fcrc_q;
    cv_d   = v_edge && seen_q;
    seen_d = seen_q | v_edge;
  end
  // CRC registers
  always_ff @(posedge clk_100) begin
    if (!reset) begin
      crc_q  <= 16'hFFFF;
      fcrc_q <= '0;
      cv_q   <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      crc_q  <= crc_d;
      fcrc_q <= fcrc_d;
      cv_q   <= cv_d;
      seen_q <= seen_d;
    end
  end
  assign frame_crc = fcrc_q;
  assign crc_valid = cv_q;
`else
  assign frame_crc = '0;
  assign crc_valid = 1'b0;
`endif
endmodule

// File: tb/tb_dvi_pixel_rx.sv
// tb_dvi_pixel_rx: directed/random stimulus against a frame-level pixel model for dvi_pixel_rx
module tb_dvi_pixel_rx;
  logic        clk_100 = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] dvi_d = '0;
  logic        dvi_de = 1'b0;
  logic        dvi_h = 1'b1;
  logic        dvi_v = 1'b1;
  logic        ready = 1'b0;
  logic [23:0] pixel_data;
  logic [10:0] pixel_x, pixel_y;
  logic        pixel_sof, pixel_valid, overflow, half_err, crc_valid;
  logic [15:0] frame_crc;
  logic [7:0]  deb;
  typedef struct packed {logic [23:0] d; logic [10:0] x; logic [10:0] y; logic sof;} pix_t;
  pix_t        exp_q[$];
  pix_t        e_m;
  logic [15:0] crc_seen[$];
  logic [23:0] lp [32];
  logic [23:0] hold0, last16;
  int          ncmp = 0, nerr = 0, npulse = 0, cur_y = 0;
  bit          sof_pend = 0, seen;

  always #5 clk_100 = ~clk_100;

  dvi_pixel_rx dut (
    .clk_100(clk_100), .reset(reset), .dvi_d(dvi_d), .dvi_de(dvi_de), .dvi_h(dvi_h), .dvi_v(dvi_v),
    .pixel_data(pixel_data), .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_sof(pixel_sof),
    .pixel_valid(pixel_valid), .ready(ready), .overflow(overflow), .half_err(half_err),
    .frame_crc(frame_crc), .crc_valid(crc_valid), .deb(deb)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_model(input int n);
    logic [15:0] c;
    logic [23:0] px;
    logic [7:0]  b;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      px = 24'(i * 32'h010101);
      for (int k = 0; k < 3; k++) begin
        b = px[23 - 8 * k -: 8];
        c = c ^ {b, 8'h00};
        for (int j = 0; j < 8; j++) c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  always @(negedge clk_100) begin
    if (reset && pixel_valid && ready) begin
      if (exp_q.size() == 0) begin
        ncmp++;
        nerr++;
        $error("FAIL unexpected_pop: observed %0h expected no pixel", pixel_data);
      end else begin
        e_m = exp_q.pop_front();
        chk("pop_data", pixel_data, e_m.d);
        chk("pop_x", pixel_x, e_m.x);
        chk("pop_y", pixel_y, e_m.y);
        chk("pop_sof", pixel_sof, e_m.sof);
      end
    end
    if (crc_valid) begin
      crc_seen.push_back(frame_crc);
      npulse++;
    end
  end

  task automatic cyc(input logic de, input logic [11:0] d);
    dvi_de = de;
    dvi_d = d;
    @(posedge clk_100);
    #1;
  endtask

  task automatic vsync();
    dvi_v = 1'b0;
    repeat (2) cyc(1'b0, 12'($urandom()));
    dvi_v = 1'b1;
    repeat (3) cyc(1'b0, 12'($urandom()));
    cur_y = 0;
    sof_pend = 1;
  endtask

  task automatic send_line(input int n, input int keep, input bit odd);
    pix_t e;
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, lp[i][11:0]);
      cyc(1'b1, lp[i][23:12]);
      e.d = lp[i];
      e.x = 11'(i);
      e.y = 11'(cur_y);
      e.sof = sof_pend;
      if (i < keep) exp_q.push_back(e);
      sof_pend = 0;
    end
    if (odd) cyc(1'b1, 12'($urandom()));
    repeat (4) cyc(1'b0, 12'($urandom()));
    cur_y++;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) lp[i] = 24'($urandom());
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk_100);
    repeat (2) @(negedge clk_100);
    chk("drain", exp_q.size(), 0);
    @(posedge clk_100);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    pix_t e;
    repeat (4) @(negedge clk_100);
    chk("rst_data", pixel_data, 0);
    chk("rst_flags", {pixel_x, pixel_y, pixel_sof, pixel_valid, overflow, half_err}, 0);
    chk("rst_crc_deb", {frame_crc, crc_valid, deb}, 0);
    @(posedge clk_100);
    #1;
    reset = 1'b1;
    ready = 1'b1;
    // one 4-pixel line
    vsync();
    lp[0] = 24'h112233; lp[1] = 24'h445566; lp[2] = 24'h778899; lp[3] = 24'hAABBCC;
    send_line(4, 4, 0);
    wait_drain();
    // two lines of 3, then a single-pixel line to measure latency
    vsync();
    fill_random(3);
    send_line(3, 3, 0);
    fill_random(3);
    send_line(3, 3, 0);
    wait_drain();
    lp[0] = 24'($urandom());
    cyc(1'b1, lp[0][11:0]);
    cyc(1'b1, lp[0][23:12]);
    e.d = lp[0]; e.x = 11'd0; e.y = 11'(cur_y); e.sof = 1'b0;
    exp_q.push_back(e);
    dvi_de = 1'b0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_100);
      if (pixel_valid) begin
        seen = 1;
        break;
      end
    end
    chk("latency_valid", seen, 1);
    @(posedge clk_100);
    #1;
    repeat (3) cyc(1'b0, 12'($urandom()));
    cur_y++;
    wait_drain();
    // overflow: 16 held, next 4 lost
    ready = 1'b0;
    vsync();
    fill_random(16);
    hold0 = lp[0];
    last16 = lp[15];
    send_line(16, 16, 0);
    chk("full_count", deb[5:1], 16);
    chk("no_ovf_16", overflow, 0);
    chk("hold_valid", pixel_valid, 1);
    chk("hold_data", pixel_data, hold0);
    fill_random(4);
    send_line(4, 0, 0);
    chk("ovf_after_17", overflow, 1);
    chk("deb_ovf", deb[0], 1);
    chk("still_full", deb[5:1], 16);
    ready = 1'b1;
    wait_drain();
    chk("empty_valid", pixel_valid, 0);
    chk("empty_hold", pixel_data, last16);
    chk("ovf_sticky", overflow, 1);
    // odd word count
    chk("half_before", half_err, 0);
    vsync();
    fill_random(1);
    send_line(1, 1, 1);
    chk("half_set", half_err, 1);
    fill_random(2);
    send_line(2, 2, 0);
    wait_drain();
    // reset mid-line with 5 pixels queued
    ready = 1'b0;
    vsync();
    fill_random(5);
    send_line(5, 5, 0);
    chk("pre_rst_count", deb[5:1], 5);
    cyc(1'b1, 12'($urandom()));
    reset = 1'b0;
    @(posedge clk_100);
    @(negedge clk_100);
    chk("rst_valid", pixel_valid, 0);
    chk("rst_clears", {overflow, half_err}, 0);
    exp_q.delete();
    @(posedge clk_100);
    #1;
    reset = 1'b1;
    ready = 1'b1;
    fill_random(3);
    send_line(3, 0, 0);
    chk("ignored_no_valid", pixel_valid, 0);
    vsync();
    fill_random(2);
    send_line(2, 2, 0);
    wait_drain();
    // two identical frames for the frame CRC
    vsync();
    crc_seen.delete();
    for (int i = 0; i < 8; i++) lp[i] = 24'(i * 32'h010101);
    send_line(8, 8, 0);
    vsync();
    send_line(8, 8, 0);
    vsync();
    wait_drain();
`ifdef DVI_RX_CRC_EN
    chk("crc_pulses", crc_seen.size(), 2);
    chk("crc_frame_a", crc_seen[0], crc_model(8));
    chk("crc_frame_b", crc_seen[1], crc_model(8));
`else
    chk("crc_pulses_off", npulse, 0);
    chk("crc_zero", frame_crc, 0);
`endif
    chk("final_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
